// File: rtl/dvi_tx_link_ctrl.sv
// DVI transmit link sequencer: gates the serializer lanes until PLL lock is qualified, sends a CTL0 preamble, then passes TMDS words.
// Optional macro TX_PRBS_EN adds a PRBS7 test pattern selectable in RUN via prbs_mode.
module dvi_tx_link_ctrl #(
    parameter int LOCK_CYC = 1024,
    parameter int PRE_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
`ifdef TX_PRBS_EN
    input  logic       prbs_mode,
`endif
    input  logic [9:0] enc_0,
    input  logic [9:0] enc_1,
    input  logic [9:0] enc_2,
    output logic [9:0] datain_0,
    output logic [9:0] datain_1,
    output logic [9:0] datain_2,
    output logic [9:0] datain_3,
    output logic       link_up,
    output logic [7:0] lock_lost
);

    localparam int CNT_MAX = (LOCK_CYC > PRE_CYC) ? LOCK_CYC : PRE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYC - 1);
    localparam logic [9:0] CTL0     = 10'b1101010100;
    localparam logic [9:0] CLK_WORD = 10'b1111100000;

    typedef enum logic [1:0] {LOCK_WAIT, PREAMBLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       lane0_q, lane1_q, lane2_q, lane3_q;
    logic [9:0]       lane0_d, lane1_d, lane2_d, lane3_d;
    logic             link_up_q, link_up_d;
    logic [7:0]       lock_lost_q, lock_lost_d;

`ifdef TX_PRBS_EN
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    logic [6:0] prbs_q, prbs_d, prbs_base, prbs_next;
    logic [9:0] prbs_word;

    // Ten serial steps of x^7+x^6+1; word bit 0 is the first bit produced.
    function automatic logic [16:0] prbs_step10(input logic [6:0] s);
        logic [6:0] st;
        logic [9:0] w;
        logic       b;
        st = s;
        w  = '0;
        for (int i = 0; i < 10; i++) begin
            b    = st[6] ^ st[5];
            w[i] = b;
            st   = {st[5:0], b};
        end
        return {st, w};
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOCK_WAIT: begin
                if (!pll_lock) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PREAMBLE: begin
                if (!pll_lock) begin
                    state_d = LOCK_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!pll_lock) begin
                    state_d = LOCK_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LOCK_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Lane words are registered from the state being entered, so they line up with state_q.
    always_comb begin
        lane0_d     = '0;
        lane1_d     = '0;
        lane2_d     = '0;
        lane3_d     = '0;
        link_up_d   = (state_d == RUN);
        lock_lost_d = lock_lost_q;
`ifdef TX_PRBS_EN
        prbs_base = (state_q == RUN) ? prbs_q : PRBS_SEED;
        {prbs_next, prbs_word} = prbs_step10(prbs_base);
        prbs_d    = (state_d == RUN) ? prbs_next : PRBS_SEED;
`endif
        case (state_d)
            PREAMBLE: begin
                lane0_d = CTL0;
                lane1_d = CTL0;
                lane2_d = CTL0;
                lane3_d = CLK_WORD;
            end
            RUN: begin
                lane0_d = enc_0;
                lane1_d = enc_1;
                lane2_d = enc_2;
                lane3_d = CLK_WORD;
`ifdef TX_PRBS_EN
                if (prbs_mode) begin
                    lane0_d = prbs_word;
                    lane1_d = prbs_word;
                    lane2_d = prbs_word;
                end
`endif
            end
            default: ;
        endcase
        if (state_q == RUN && state_d == LOCK_WAIT && lock_lost_q != 8'hFF) begin
            lock_lost_d = lock_lost_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOCK_WAIT;
            cnt_q       <= '0;
            lane0_q     <= '0;
            lane1_q     <= '0;
            lane2_q     <= '0;
            lane3_q     <= '0;
            link_up_q   <= 1'b0;
            lock_lost_q <= '0;
`ifdef TX_PRBS_EN
            prbs_q      <= PRBS_SEED;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane0_q     <= lane0_d;
            lane1_q     <= lane1_d;
            lane2_q     <= lane2_d;
            lane3_q     <= lane3_d;
            link_up_q   <= link_up_d;
            lock_lost_q <= lock_lost_d;
`ifdef TX_PRBS_EN
            prbs_q      <= prbs_d;
`endif
        end
    end

    assign datain_0  = lane0_q;
    assign datain_1  = lane1_q;
    assign datain_2  = lane2_q;
    assign datain_3  = lane3_q;
    assign link_up   = link_up_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_dvi_tx_link_ctrl.sv
// Directed bench for dvi_tx_link_ctrl with LOCK_CYC=8, PRE_CYC=4; PRBS scenario built when TX_PRBS_EN is defined.
module tb_dvi_tx_link_ctrl;

    localparam logic [40:0] ZERO_V = 41'd0;
    localparam logic [40:0] PRE_V  = {10'h354, 10'h354, 10'h354, 10'h3E0, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic [9:0] enc_0, enc_1, enc_2;
    logic [9:0] datain_0, datain_1, datain_2, datain_3;
    logic       link_up;
    logic [7:0] lock_lost;
`ifdef TX_PRBS_EN
    logic       prbs_mode;
`endif

    int checks = 0;
    int errors = 0;

    dvi_tx_link_ctrl #(.LOCK_CYC(8), .PRE_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
`ifdef TX_PRBS_EN
        .prbs_mode(prbs_mode),
`endif
        .enc_0    (enc_0),
        .enc_1    (enc_1),
        .enc_2    (enc_2),
        .datain_0 (datain_0),
        .datain_1 (datain_1),
        .datain_2 (datain_2),
        .datain_3 (datain_3),
        .link_up  (link_up),
        .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    wire [40:0] obs = {datain_0, datain_1, datain_2, datain_3, link_up};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Twelve high cycles from LOCK_WAIT with a cleared counter land in RUN.
    task automatic bring_up;
        pll_lock = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pll_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== ZERO_V || lock_lost !== 8'd0) begin
                errors++;
                $display("FAIL reset_cycle%0d: got %h/%h want %h/00", i, obs, lock_lost, ZERO_V);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== ZERO_V || lock_lost !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: got %h/%h want %h/00", obs, lock_lost, ZERO_V);
        end
    endtask

    task automatic test_startup;
        logic [40:0] exp;
        do_reset();
        pll_lock = 1'b1;
        enc_0 = 10'h111; enc_1 = 10'h222; enc_2 = 10'h0AB;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i <= 7)       exp = ZERO_V;
            else if (i <= 11) exp = PRE_V;
            else              exp = {10'h111, 10'h222, 10'h0AB, 10'h3E0, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL startup_t%0d: got %h want %h", i, obs, exp);
            end
        end
        for (int i = 0; i < 6; i++) begin
            enc_0 = 10'(i * 97 + 5);
            enc_1 = 10'(i * 211 + 3);
            enc_2 = 10'(1023 - i * 37);
            exp = {enc_0, enc_1, enc_2, 10'h3E0, 1'b1};
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL passthru_%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_lock_glitch;
        do_reset();
        pll_lock = 1'b1;
        repeat (6) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (obs !== ((i == 8) ? PRE_V : ZERO_V)) begin
                errors++;
                $display("FAIL glitch_t%0d: got %h want %h", i, obs, (i == 8) ? PRE_V : ZERO_V);
            end
        end
    endtask

    task automatic test_terminal_low;
        do_reset();
        pll_lock = 1'b1;
        repeat (7) tick();
        pll_lock = 1'b0;
        tick();
        checks++;
        if (obs !== ZERO_V) begin
            errors++;
            $display("FAIL terminal_low: got %h want %h", obs, ZERO_V);
        end
        pll_lock = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (obs !== ((i == 8) ? PRE_V : ZERO_V)) begin
                errors++;
                $display("FAIL terminal_requal_t%0d: got %h want %h", i, obs, (i == 8) ? PRE_V : ZERO_V);
            end
        end
    endtask

    task automatic test_run_loss;
        do_reset();
        enc_0 = 10'h3FF; enc_1 = 10'h001; enc_2 = 10'h155;
        bring_up();
        pll_lock = 1'b0;
        tick();
        checks++;
        if (obs !== ZERO_V || lock_lost !== 8'd1) begin
            errors++;
            $display("FAIL run_loss: got %h/%h want %h/01", obs, lock_lost, ZERO_V);
        end
        pll_lock = 1'b1;
        repeat (9) tick();
        checks++;
        if (obs !== PRE_V) begin
            errors++;
            $display("FAIL requal_preamble: got %h want %h", obs, PRE_V);
        end
        pll_lock = 1'b0;
        tick();
        checks++;
        if (obs !== ZERO_V || lock_lost !== 8'd1) begin
            errors++;
            $display("FAIL preamble_loss: got %h/%h want %h/01", obs, lock_lost, ZERO_V);
        end
        bring_up();
        checks++;
        if (obs !== {10'h3FF, 10'h001, 10'h155, 10'h3E0, 1'b1} || lock_lost !== 8'd1) begin
            errors++;
            $display("FAIL resequence_run: got %h/%h want run/01", obs, lock_lost);
        end
    endtask

    task automatic test_saturation;
        logic [7:0] exp_ll;
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            bring_up();
            pll_lock = 1'b0;
            tick();
            exp_ll = (i >= 255) ? 8'hFF : 8'(i);
            checks++;
            if (lock_lost !== exp_ll) begin
                errors++;
                $display("FAIL sat_loss%0d: got %h want %h", i, lock_lost, exp_ll);
            end
        end
        bring_up();
        checks++;
        if (link_up !== 1'b1 || lock_lost !== 8'hFF) begin
            errors++;
            $display("FAIL sat_run: got %b/%h want 1/ff", link_up, lock_lost);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== ZERO_V || lock_lost !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_run: got %h/%h want %h/00", obs, lock_lost, ZERO_V);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (obs !== ((i == 8) ? PRE_V : ZERO_V)) begin
                errors++;
                $display("FAIL post_rst_t%0d: got %h want %h", i, obs, (i == 8) ? PRE_V : ZERO_V);
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pll_lock = 1'b0;
        checks++;
        if (obs !== ZERO_V) begin
            errors++;
            $display("FAIL rst_mid_preamble: got %h want %h", obs, ZERO_V);
        end
    endtask

`ifdef TX_PRBS_EN
    task automatic test_prbs;
        logic [6:0] lfsr;
        logic [9:0] ref_w;
        logic       nb;
        do_reset();
        prbs_mode = 1'b1;
        enc_0 = 10'h0F0; enc_1 = 10'h00F; enc_2 = 10'h2AA;
        pll_lock = 1'b1;
        repeat (11) tick();
        lfsr = 7'h7F;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 10; k++) begin
                nb = lfsr[6] ^ lfsr[5];
                ref_w[k] = nb;
                lfsr = {lfsr[5:0], nb};
            end
            tick();
            checks++;
            if (obs !== {ref_w, ref_w, ref_w, 10'h3E0, 1'b1}) begin
                errors++;
                $display("FAIL prbs_word%0d: got %h want %h", n, obs, {ref_w, ref_w, ref_w, 10'h3E0, 1'b1});
            end
        end
        prbs_mode = 1'b0;
        tick();
        checks++;
        if (obs !== {10'h0F0, 10'h00F, 10'h2AA, 10'h3E0, 1'b1}) begin
            errors++;
            $display("FAIL prbs_off: got %h want passthrough", obs);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        pll_lock = 1'b0;
        enc_0 = '0; enc_1 = '0; enc_2 = '0;
`ifdef TX_PRBS_EN
        prbs_mode = 1'b0;
`endif
        test_reset();
        test_startup();
        test_lock_glitch();
        test_terminal_low();
        test_run_loss();
        test_saturation();
`ifdef TX_PRBS_EN
        test_prbs();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
